// File: rtl/life_engine_if.sv
// Control, edit and status signals of the life engine, grouped for port
// connection. The master side drives controls; the slave side is the engine.
interface life_engine_if #(
    parameter int unsigned X     = 8,
    parameter int unsigned Y     = 8,
    parameter int unsigned LOG2X = 3,
    parameter int unsigned LOG2Y = 3,
    parameter int unsigned GENW  = 16
);
    logic             run;
    logic             step;
    logic             tick;
    logic             clear;
    logic             key_flip;
    logic [LOG2X-1:0] cursor_x;
    logic [LOG2Y-1:0] cursor_y;
    logic [X*Y-1:0]   data;
    logic [GENW-1:0]  gen_count;
    logic             running;
    logic             stable;

    modport master (
        output run, step, tick, clear, key_flip, cursor_x, cursor_y,
        input  data, gen_count, running, stable
    );

    modport slave (
        input  run, step, tick, clear, key_flip, cursor_x, cursor_y,
        output data, gen_count, running, stable
    );
endinterface

// File: rtl/life_engine.sv
// Parallel Game-of-Life grid with run/step/halt control, cursor edits and a
// generation counter; birth/survival rules and edge wrapping are parameters.
module life_engine #(
    parameter int unsigned X       = 8,
    parameter int unsigned Y       = 8,
    parameter int unsigned LOG2X   = 3,
    parameter int unsigned LOG2Y   = 3,
    parameter logic [8:0]  BIRTH   = 9'b000001000,
    parameter logic [8:0]  SURVIVE = 9'b000001100,
    parameter bit          WRAP    = 1'b1,
    parameter int unsigned GENW    = 16
) (
    input logic          clk,
    input logic          reset,
    life_engine_if.slave bus
);
    localparam int unsigned N  = X * Y;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HALT, CLEAR} state_e;

    state_e          state_q;
    logic [N-1:0]    data_q;
    logic [GENW-1:0] gen_q;
    logic            stable_q;
    logic            key_q;

    logic [N-1:0]    life_d;
    logic [N-1:0]    edit_mask;
    logic            edit_ok;
    logic [3:0]      ncount;
    int unsigned     nidx;
    logic [31:0]     cx_w;
    logic [31:0]     cy_w;
    logic            key_fall;
    logic            do_gen;
    logic            do_edit;
    logic            unchanged;

    assign cx_w = {{(32-LOG2X){1'b0}}, bus.cursor_x};
    assign cy_w = {{(32-LOG2Y){1'b0}}, bus.cursor_y};

    // Neighbour offsets run 0..2 (meaning -1..+1) so all index math stays unsigned.
    always_comb begin
        life_d = '0;
        ncount = '0;
        nidx   = 0;
        for (int unsigned y = 0; y < Y; y++) begin
            for (int unsigned x = 0; x < X; x++) begin
                ncount = '0;
                for (int unsigned dy = 0; dy < 3; dy++) begin
                    for (int unsigned dx = 0; dx < 3; dx++) begin
                        if (!(dx == 1 && dy == 1)) begin
                            if (WRAP) begin
                                nidx   = ((y + Y + dy - 1) % Y) * X + ((x + X + dx - 1) % X);
                                ncount = ncount + {3'b000, data_q[IW'(nidx)]};
                            end else if ((x + dx >= 1) && (x + dx <= X) &&
                                         (y + dy >= 1) && (y + dy <= Y)) begin
                                nidx   = (y + dy - 1) * X + (x + dx - 1);
                                ncount = ncount + {3'b000, data_q[IW'(nidx)]};
                            end
                        end
                    end
                end
                life_d[IW'(y * X + x)] = data_q[IW'(y * X + x)] ? SURVIVE[ncount] : BIRTH[ncount];
            end
        end
    end

    always_comb begin
        edit_ok   = 1'b0;
        edit_mask = '0;
        if ((cx_w < X) && (cy_w < Y)) begin
            edit_ok = 1'b1;
            edit_mask[IW'(cy_w * X + cx_w)] = 1'b1;
        end
    end

    assign key_fall  = key_q & ~bus.key_flip;
    assign unchanged = (life_d == data_q);
    assign do_gen    = ((state_q == IDLE) && !bus.run && bus.step) ||
                       ((state_q == RUN) && bus.run && bus.tick);
    assign do_edit   = key_fall && edit_ok && ((state_q == IDLE) || (state_q == HALT));

    // Clear outranks a generation, which outranks an edit on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
            key_q    <= 1'b0;
        end else begin
            key_q <= bus.key_flip;
            if (bus.clear) begin
                state_q  <= CLEAR;
                data_q   <= '0;
                gen_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                if (do_gen) begin
                    data_q   <= life_d;
                    gen_q    <= gen_q + GENW'(1);
                    stable_q <= unchanged;
                end else if (do_edit) begin
                    data_q   <= data_q ^ edit_mask;
                    stable_q <= 1'b0;
                end
                unique case (state_q)
                    IDLE:  if (bus.run) state_q <= RUN;
                    RUN: begin
                        if (!bus.run)                   state_q <= IDLE;
                        else if (bus.tick && unchanged) state_q <= HALT;
                    end
                    HALT:  if (!bus.run) state_q <= IDLE;
                    CLEAR: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.gen_count = gen_q;
    assign bus.stable    = stable_q;
    assign bus.running   = (state_q == RUN);
endmodule

// File: tb/tb_life_engine.sv
// Scoreboard bench for life_engine: stimulus queues expected outputs tagged
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_life_engine;
    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       run   = 1'b0;
    logic       step  = 1'b0;
    logic       tick  = 1'b0;
    logic       clear = 1'b0;
    logic       key   = 1'b0;
    logic [3:0] cx    = '0;
    logic [2:0] cy    = '0;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    life_engine_if #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .GENW(16)) b0 ();
    life_engine_if #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .GENW(16)) b1 ();
    life_engine_if #(.X(8), .Y(8), .LOG2X(4), .LOG2Y(3), .GENW(2))  b2 ();

    assign b0.run = run;  assign b0.step = step;  assign b0.tick = tick;
    assign b0.clear = clear;  assign b0.key_flip = key;
    assign b0.cursor_x = cx[2:0];  assign b0.cursor_y = cy;
    assign b1.run = run;  assign b1.step = step;  assign b1.tick = tick;
    assign b1.clear = clear;  assign b1.key_flip = key;
    assign b1.cursor_x = cx[2:0];  assign b1.cursor_y = cy;
    assign b2.run = run;  assign b2.step = step;  assign b2.tick = tick;
    assign b2.clear = clear;  assign b2.key_flip = key;
    assign b2.cursor_x = cx;  assign b2.cursor_y = cy;

    life_engine #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .BIRTH(9'b000001000),
                  .SURVIVE(9'b000001100), .WRAP(1'b1), .GENW(16))
        dut0 (.clk(clk), .reset(reset), .bus(b0));
    life_engine #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .BIRTH(9'b000001000),
                  .SURVIVE(9'b000001100), .WRAP(1'b0), .GENW(16))
        dut1 (.clk(clk), .reset(reset), .bus(b1));
    life_engine #(.X(8), .Y(8), .LOG2X(4), .LOG2Y(3), .BIRTH(9'b000001000),
                  .SURVIVE(9'b000001100), .WRAP(1'b1), .GENW(2))
        dut2 (.clk(clk), .reset(reset), .bus(b2));

    typedef struct {
        string       name;
        int unsigned cyc;
        int unsigned dut;
        logic [63:0] data;
        logic [15:0] gen;
        logic        stable;
        logic        running;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [63:0] ad;
    logic [15:0] ag;
    logic        ast, arn;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            case (e.dut)
                0: begin ad = b0.data; ag = b0.gen_count; ast = b0.stable; arn = b0.running; end
                1: begin ad = b1.data; ag = b1.gen_count; ast = b1.stable; arn = b1.running; end
                default: begin ad = b2.data; ag = 16'(b2.gen_count); ast = b2.stable; arn = b2.running; end
            endcase
            n_cmp++;
            if (e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if (ad !== e.data || ag !== e.gen || ast !== e.stable || arn !== e.running) begin
                n_bad++;
                $display("FAIL %s (dut%0d): got data=%h gen=%0d stable=%b running=%b, want data=%h gen=%0d stable=%b running=%b",
                         e.name, e.dut, ad, ag, ast, arn, e.data, e.gen, e.stable, e.running);
            end
        end
    end

    task automatic expect_out(input string nm, input int unsigned d, input logic [63:0] dat,
                              input logic [15:0] g, input logic st, input logic rn,
                              input int unsigned dly);
        exp_t e;
        e.name = nm; e.cyc = cyc + dly; e.dut = d;
        e.data = dat; e.gen = g; e.stable = st; e.running = rn;
        sb.push_back(e);
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic edit(input int unsigned x, input int unsigned y);
        cx = 4'(x); cy = 3'(y); key = 1'b1; cyc1();
        key = 1'b0; cyc1();
    endtask

    task automatic clear_grid();
        clear = 1'b1; cyc1();
        clear = 1'b0; cyc1();
    endtask

    function automatic logic [63:0] bt(input int unsigned a);
        return 64'd1 << a;
    endfunction

    logic [63:0] BL_H, BL_V, BLK;

    initial begin
        BL_H = bt(26) | bt(27) | bt(28);
        BL_V = bt(19) | bt(27) | bt(35);
        BLK  = bt(0) | bt(1) | bt(8) | bt(9);

        repeat (3) cyc1();
        expect_out("reset_state", 0, '0, 0, 0, 0, 1);
        expect_out("reset_state_genw2", 2, '0, 0, 0, 0, 1);
        cyc1();
        reset = 1'b1; cyc1();

        // Blinker, stepped four times; the 2-bit counter instance wraps to 0.
        edit(2, 3); edit(3, 3); edit(4, 3);
        expect_out("blinker_loaded", 0, BL_H, 0, 0, 0, 1); cyc1();
        step = 1'b1; expect_out("blinker_step1", 0, BL_V, 1, 0, 0, 1); cyc1();
        step = 1'b0; cyc1();
        step = 1'b1; expect_out("blinker_step2", 0, BL_H, 2, 0, 0, 1); cyc1();
        step = 1'b0; cyc1();
        step = 1'b1; cyc1();
        step = 1'b0; cyc1();
        step = 1'b1;
        expect_out("blinker_step4", 0, BL_H, 4, 0, 0, 1);
        expect_out("gen_wrap_genw2", 2, BL_H, 0, 0, 0, 1);
        cyc1();
        step = 1'b0;
        clear = 1'b1; expect_out("clear_pulse", 0, '0, 0, 0, 0, 1); cyc1();
        clear = 1'b0; cyc1();

        step = 1'b1; expect_out("step_empty_stable", 0, '0, 1, 1, 0, 1); cyc1();
        step = 1'b0;
        clear_grid();

        // Block: run, tick on cycle 3 -> auto-halt; ticks then ignored.
        edit(0, 0); edit(1, 0); edit(0, 1); edit(1, 1);
        run = 1'b1; expect_out("block_run", 0, BLK, 0, 0, 1, 1); cyc1();
        cyc1();
        tick = 1'b1; expect_out("block_tick_halt", 0, BLK, 1, 1, 0, 1); cyc1();
        repeat (9) cyc1();
        expect_out("block_ticks_ignored", 0, BLK, 1, 1, 0, 1); cyc1();
        edit(5, 5);
        expect_out("halt_edit_stays_halt", 0, BLK | bt(45), 1, 0, 0, 1); cyc1();
        tick = 1'b0; run = 1'b0;
        expect_out("halt_to_idle", 0, BLK | bt(45), 1, 0, 0, 1); cyc1();
        clear_grid();

        // Edits: idle toggles, run ignores, out-of-range cursor ignored.
        edit(3, 2);
        expect_out("edit_idle_toggle", 0, bt(19), 0, 0, 0, 1); cyc1();
        run = 1'b1; cyc1();
        key = 1'b1; cyc1();
        key = 1'b0; expect_out("edit_in_run_ignored", 0, bt(19), 0, 0, 1, 1); cyc1();
        run = 1'b0; cyc1();
        cx = 4'd9; cy = 3'd2; key = 1'b1; cyc1();
        key = 1'b0; expect_out("edit_out_of_range", 2, bt(19), 0, 0, 0, 1); cyc1();
        clear_grid();

        // Row-0 triple straddling the x edge.
        edit(7, 0); edit(0, 0); edit(1, 0);
        step = 1'b1;
        expect_out("wrap_step", 0, bt(56) | bt(0) | bt(8), 1, 0, 0, 1);
        expect_out("nowrap_step", 1, '0, 1, 0, 0, 1);
        cyc1();
        step = 1'b0;
        clear_grid();

        // Clear beats a same-cycle tick; CLEAR lasts exactly one cycle.
        edit(2, 3); edit(3, 3); edit(4, 3);
        run = 1'b1; cyc1();
        tick = 1'b1; expect_out("run_tick_gen", 0, BL_V, 1, 0, 1, 1); cyc1();
        clear = 1'b1; expect_out("clear_with_tick", 0, '0, 0, 0, 0, 1); cyc1();
        clear = 1'b0; tick = 1'b0;
        expect_out("clear_to_idle", 0, '0, 0, 0, 0, 1); cyc1();
        expect_out("idle_to_run_after_clear", 0, '0, 0, 0, 1, 1); cyc1();
        run = 1'b0; cyc1();

        // Asynchronous reset mid-RUN, asserted between clock edges.
        edit(2, 3); edit(3, 3); edit(4, 3);
        run = 1'b1; cyc1();
        tick = 1'b1; expect_out("pre_reset_gen", 0, BL_V, 1, 0, 1, 1); cyc1();
        tick = 1'b0; cyc1();
        #2;
        reset = 1'b0;
        expect_out("async_reset", 0, '0, 0, 0, 0, 0);
        cyc1();
        reset = 1'b1;
        expect_out("reset_release_idle", 0, '0, 0, 0, 0, 0);
        expect_out("resume_run_empty", 0, '0, 0, 0, 1, 1);
        cyc1();
        run = 1'b0;
        repeat (3) cyc1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning): X, 8, grid width; Y, 8, grid height; LOG2X, 3, cursor_x width; LOG2Y, 3, cursor_y width; BIRTH, 9'b000001000, bit n=1 means a dead cell with n live neighbours is born; SURVIVE, 9'b000001100, bit n=1 means a live cell with n live neighbours survives; WRAP, 1, 1=toroidal edges, 0=cells outside the grid count as dead; GENW, 16, generation counter width.
REQ-002 The module SHALL have this port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have this port: reset, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have this port: run, input, 1, level; request continuous evolution.
REQ-005 The module SHALL have this port: step, input, 1, single-cycle pulse; request one generation while idle.
REQ-006 The module SHALL have this port: tick, input, 1, generation-rate strobe used while running.
REQ-007 The module SHALL have this port: clear, input, 1, pulse; empty the grid.
REQ-008 The module SHALL have this port: key_flip, input, 1, edit key level.
REQ-009 The module SHALL have these ports: cursor_x, input, LOG2X, edit column; cursor_y, input, LOG2Y, edit row.
REQ-010 The module SHALL have this port: data, output reg, X*Y, grid; cell (x,y) is data[y*X+x], 1 = alive.
REQ-011 The module SHALL have this port: gen_count, output reg, GENW, generations computed since reset or clear.
REQ-012 The module SHALL have these ports: running, output, 1, high in state RUN; stable, output reg, 1, last generation left the grid unchanged.

Function
REQ-013 Next state SHALL be computed for all cells in parallel: n = live count of the 8 neighbours (0..8); new = data[i] ? SURVIVE[n] : BIRTH[n].
REQ-014 With WRAP=1, neighbour coordinates SHALL wrap modulo X and Y; with WRAP=0, out-of-grid neighbours SHALL count as 0.
REQ-015 The FSM SHALL have states IDLE, RUN, HALT, CLEAR.
REQ-016 IDLE: run=1 -> RUN; step=1 (and run=0) -> one generation applied on this edge, remaining in IDLE.
REQ-017 RUN: each cycle with tick=1 applies one generation; run=0 -> IDLE; ticks while in IDLE or HALT SHALL be ignored.
REQ-018 In RUN or on step, a generation whose result equals the current grid SHALL still be applied and counted, SHALL set stable=1, and in RUN SHALL move to HALT (auto-pause).
REQ-019 HALT: grid frozen; run=0 -> IDLE; run held high keeps HALT.
REQ-020 clear=1 in any state SHALL enter CLEAR on the next edge, with data=0, gen_count=0 and stable=0; CLEAR SHALL go to IDLE after one cycle.
REQ-021 Priority on one edge SHALL be clear > generation > edit.
REQ-022 key_flip SHALL be registered every cycle; a falling edge (registered=1, current=0) in IDLE or HALT SHALL toggle cell (cursor_x, cursor_y) and clear stable.
REQ-023 A falling edge of key_flip SHALL be ignored in RUN and CLEAR.
REQ-024 An edit with cursor_x>=X or cursor_y>=Y SHALL be ignored.
REQ-025 An edit toggle in HALT SHALL NOT leave HALT.
REQ-026 gen_count SHALL increment by 1 per applied generation and wrap modulo 2^GENW.
REQ-027 A generation that changes the grid SHALL clear stable.

Reset
REQ-028 While reset=0, data SHALL be 0, gen_count SHALL be 0, stable SHALL be 0, the FSM SHALL be in IDLE and the key_flip register SHALL be 0, asynchronously and independent of clk.
REQ-029 Deassertion of reset during RUN SHALL resume in IDLE with an empty grid.

Verification
REQ-030 Blinker, default 8x8, cells 26,27,28 alive, step pulse -> data has only bits 19,27,35 set, gen_count=1, stable=0; second step -> bits 26,27,28, gen_count=2.
REQ-031 Block, cells 0,1,8,9 alive, run=1, tick at cycle 3 -> gen_count=1, stable=1, state HALT, data unchanged; ticks held 10 cycles -> gen_count stays 1; run=0 -> IDLE.
REQ-032 Wrap: cells 7,0,1 alive (row 0 across edge), WRAP=1, step -> only bits 56,0,8 set; same stimulus with WRAP=0 -> data=0.
REQ-033 Edit: cursor (3,2), key_flip 1->0 in IDLE -> bit 19 toggles once; same in RUN -> no change; cursor_x=9 with X=8 and LOG2X=4 -> no change.
REQ-034 Clear with tick in the same cycle during RUN -> next cycle data=0, gen_count=0, state IDLE one cycle later.
REQ-035 Reset pulse mid-RUN at an arbitrary phase relative to clk -> outputs zero immediately, before the next clk edge.
